// File: rtl/skolem_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : skolem_sweep_ctrl_pkg
// Purpose  : Shared types and helpers for the Skolem sweep controller.
//            Holds the sweep state encoding and the truncated-multiply
//            signed-compare used both by the checker and by its bench.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package skolem_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    CAPTURE = 3'd2,
    SEARCH  = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Returns ((x*s) mod 2^w) <=s t, with both sides read as w-bit two's
  // complement. Operands are carried in 32-bit containers; only the low
  // w bits matter, so the 32-bit product truncation is harmless (w <= 32).
  function automatic logic mul_sle(input logic [31:0] x,
                                   input logic [31:0] s,
                                   input logic [31:0] t,
                                   input int          w);
    logic [31:0]        prod;
    logic signed [31:0] p_se;
    logic signed [31:0] t_se;
    int                 sh;
    sh   = 32 - w;
    prod = x * s;
    // Left-justify then arithmetic-shift back to sign-extend from bit w-1.
    p_se = $signed(prod << sh) >>> sh;
    t_se = $signed(t << sh) >>> sh;
    return (p_se <= t_se);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skolem_sle_mul_eval.sv
`default_nettype none
// ============================================================================
// Module   : skolem_sle_mul_eval
// Purpose  : Combinational check ((x*s) mod 2^W) <=s t.
// Ports    : i_x  [W-1:0]  candidate / captured x
//            i_s  [W-1:0]  s operand
//            i_t  [W-1:0]  t operand (signed bound)
//            o_le          1 when the truncated product is <= t (signed)
// Revision : 1.0 - initial release
// ============================================================================
module skolem_sle_mul_eval
  import skolem_sweep_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_s,
  input  logic [W-1:0] i_t,
  output logic         o_le
);

  assign o_le = mul_sle(32'(i_x), 32'(i_s), 32'(i_t), W);

endmodule
`default_nettype wire

// File: rtl/skolem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : skolem_sweep_ctrl
// Purpose  : Drives an external Skolem-function instance over a range of
//            (s,t) pairs, checks the returned x, brute-force searches each
//            pair for invertibility and counts invertible pairs / failures.
// Ports    : clk, rst_n (sync, active low), start, abort
//            sweep_lo/sweep_hi [2W-1:0]  inclusive pair range {t,s}
//            sk_s/sk_t [W-1:0]           operands to the Skolem instance
//            sk_x [W-1:0]                x returned by the instance
//            busy, done                  status / completion pulse
//            inv_cnt/fail_cnt [2W:0]     invertible pairs / Skolem failures
//            first_fail [2W-1:0]         index of first failing pair
// Revision : 1.0 - initial release
// ============================================================================
module skolem_sweep_ctrl
  import skolem_sweep_ctrl_pkg::*;
#(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [2*W-1:0] sweep_lo,
  input  logic [2*W-1:0] sweep_hi,
  output logic [W-1:0]   sk_s,
  output logic [W-1:0]   sk_t,
  input  logic [W-1:0]   sk_x,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   inv_cnt,
  output logic [2*W:0]   fail_cnt,
  output logic [2*W-1:0] first_fail
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] c_settle_last = SCW'(SETTLE - 1);
  localparam logic [W-1:0]   c_cand_last   = '1;

  state_t           r_state;
  state_t           w_next;
  logic [2*W-1:0]   r_idx;
  logic [2*W-1:0]   r_hi;
  logic [SCW-1:0]   r_settle;
  logic [W-1:0]     r_xs;
  logic [W-1:0]     r_cand;
  logic             r_inv;
  logic [2*W:0]     r_inv_cnt;
  logic [2*W:0]     r_fail_cnt;
  logic [2*W-1:0]   r_first_fail;

  logic             w_abort;
  logic             w_settled;
  logic             w_hit;
  logic             w_sk_ok;

  // Operands follow the index directly; idx is stable from APPLY to CHECK
  // and resets to zero, which gives sk_s = sk_t = 0 out of reset.
  assign sk_s       = r_idx[W-1:0];
  assign sk_t       = r_idx[2*W-1:W];
  assign inv_cnt    = r_inv_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign first_fail = r_first_fail;

  assign w_abort    = abort && (r_state != IDLE);
  assign w_settled  = (r_settle == c_settle_last);

  // Check of the captured Skolem output for the current pair.
  skolem_sle_mul_eval #(.W(W)) u_eval_sk (
    .i_x  (r_xs),
    .i_s  (r_idx[W-1:0]),
    .i_t  (r_idx[2*W-1:W]),
    .o_le (w_sk_ok)
  );

  // Brute-force candidate evaluation during SEARCH.
  skolem_sle_mul_eval #(.W(W)) u_eval_cand (
    .i_x  (r_cand),
    .i_s  (r_idx[W-1:0]),
    .i_t  (r_idx[2*W-1:W]),
    .o_le (w_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (sweep_lo > sweep_hi) ? DONE : APPLY;
      end
      APPLY: begin
        busy = 1'b1;
        if (w_settled) w_next = CAPTURE;
      end
      CAPTURE: begin
        busy   = 1'b1;
        w_next = SEARCH;
      end
      SEARCH: begin
        busy = 1'b1;
        if (w_hit || (r_cand == c_cand_last)) w_next = CHECK;
      end
      CHECK: begin
        busy   = 1'b1;
        w_next = (r_idx == r_hi) ? DONE : APPLY;
      end
      DONE: begin
        done   = !abort;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  // Datapath. An abort freezes everything so partial counts survive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_hi         <= '0;
      r_settle     <= '0;
      r_xs         <= '0;
      r_cand       <= '0;
      r_inv        <= 1'b0;
      r_inv_cnt    <= '0;
      r_fail_cnt   <= '0;
      r_first_fail <= '0;
    end else if (!w_abort) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx        <= sweep_lo;
            r_hi         <= sweep_hi;
            r_settle     <= '0;
            r_inv_cnt    <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
          end
        end
        APPLY: begin
          if (!w_settled) r_settle <= r_settle + 1'b1;
        end
        CAPTURE: begin
          r_xs   <= sk_x;
          r_cand <= '0;
        end
        SEARCH: begin
          if (w_hit)                      r_inv  <= 1'b1;
          else if (r_cand == c_cand_last) r_inv  <= 1'b0;
          else                            r_cand <= r_cand + 1'b1;
        end
        CHECK: begin
          if (r_inv) begin
            r_inv_cnt <= r_inv_cnt + 1'b1;
            if (!w_sk_ok) begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
              if (r_fail_cnt == '0) r_first_fail <= r_idx;
            end
          end
          // Stop at sweep_hi without incrementing, so idx never wraps.
          if (r_idx != r_hi) begin
            r_idx    <= r_idx + 1'b1;
            r_settle <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_skolem_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_skolem_sweep_ctrl
// Purpose  : Self-checking bench for skolem_sweep_ctrl (W=4, SETTLE=1),
//            with a stub Skolem instance (constant x or ideal reference).
// Revision : 1.0 - initial release
// ============================================================================
module tb_skolem_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] sweep_lo = '0;
  logic [7:0] sweep_hi = '0;
  logic [3:0] sk_s, sk_t, sk_x;
  logic       busy, done;
  logic [8:0] inv_cnt, fail_cnt;
  logic [7:0] first_fail;

  bit         stub_mode = 1'b0;   // 0: constant x, 1: ideal reference
  logic [3:0] stub_const = '0;
  logic [3:0] stub_ideal;

  int n_total = 0;
  int n_pass  = 0;
  int done_pulses = 0;

  skolem_sweep_ctrl #(.W(4), .SETTLE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .sweep_lo   (sweep_lo),
    .sweep_hi   (sweep_hi),
    .sk_s       (sk_s),
    .sk_t       (sk_t),
    .sk_x       (sk_x),
    .busy       (busy),
    .done       (done),
    .inv_cnt    (inv_cnt),
    .fail_cnt   (fail_cnt),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  // Independent 4-bit reference: low nibble of x*s, signed, vs signed t.
  function automatic bit ref_le(input logic [3:0] x, input logic [3:0] s,
                                input logic [3:0] t);
    logic [7:0]        p;
    logic signed [3:0] ps;
    logic signed [3:0] ts;
    p  = x * s;
    ps = p[3:0];
    ts = t;
    return ps <= ts;
  endfunction

  always_comb begin
    stub_ideal = '0;
    for (int x = 15; x >= 0; x--)
      if (ref_le(4'(x), sk_s, sk_t)) stub_ideal = 4'(x);
    sk_x = stub_mode ? stub_ideal : stub_const;
  end

  always @(negedge clk) if (done) done_pulses++;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
  endtask

  // Pulse start, then wait (bounded) for done; count busy cycles.
  task automatic run_sweep(input logic [7:0] lo, input logic [7:0] hi,
                           input bit mode, input logic [3:0] xc,
                           output int busy_cyc, output int pulses);
    int  d0;
    bit  seen;
    sweep_lo   = lo;
    sweep_hi   = hi;
    stub_mode  = mode;
    stub_const = xc;
    d0         = done_pulses;
    busy_cyc   = 0;
    seen       = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8000 && !seen; c++) begin
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    pulses = done_pulses - d0;
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    bit         mode;
    logic [3:0] xc;
    int         e_inv;
    int         e_fail;
    logic [7:0] e_ff;
    int         e_busy;
  } vec_t;

  vec_t vecs[8];
  int   model_inv;

  initial begin
    int bc, pc, d0;
    bit found;

    // lo, hi, mode, x, inv, fail, first_fail, busy cycles
    vecs[0] = '{8'h80, 8'h80, 1'b0, 4'h0, 0, 0, 8'h00, 19}; // s=0,t=-8: no x
    vecs[1] = '{8'h81, 8'h81, 1'b0, 4'h0, 1, 1, 8'h81, 12}; // hit at cand 8
    vecs[2] = '{8'h81, 8'h81, 1'b0, 4'h8, 1, 0, 8'h00, 12}; // x=8 -> -8
    vecs[3] = '{8'h81, 8'h82, 1'b0, 4'h0, 2, 2, 8'h81, 20}; // s=2 hits at 4
    vecs[4] = '{8'h05, 8'h04, 1'b0, 4'h0, 0, 0, 8'h00, 0};  // empty range
    vecs[5] = '{8'h00, 8'h03, 1'b0, 4'h0, 4, 0, 8'h00, 16}; // t=0, x=0 ok
    vecs[6] = '{8'h01, 8'h01, 1'b0, 4'h5, 1, 1, 8'h01, 4};  // 5 > 0 fails
    vecs[7] = '{8'h80, 8'h81, 1'b0, 4'h0, 1, 1, 8'h81, 31}; // non-inv no fail

    model_inv = 0;
    for (int p = 0; p < 256; p++) begin
      found = 1'b0;
      for (int x = 0; x < 16; x++)
        if (ref_le(4'(x), 4'(p), 4'(p >> 4))) found = 1'b1;
      if (found) model_inv++;
    end

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_inv", int'(inv_cnt), 0);
    chk("rst_sk_s", int'(sk_s), 0);

    // Table-driven sweeps
    for (int i = 0; i < 8; i++) begin
      run_sweep(vecs[i].lo, vecs[i].hi, vecs[i].mode, vecs[i].xc, bc, pc);
      chk($sformatf("v%0d_inv", i), int'(inv_cnt), vecs[i].e_inv);
      chk($sformatf("v%0d_fail", i), int'(fail_cnt), vecs[i].e_fail);
      chk($sformatf("v%0d_first_fail", i), int'(first_fail), int'(vecs[i].e_ff));
      chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].e_busy);
      chk($sformatf("v%0d_done_pulses", i), pc, 1);
      chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    // Reset while SEARCH of pair 0x80 is running (after 0x7F counted)
    sweep_lo = 8'h7F; sweep_hi = 8'h80; stub_mode = 1'b0; stub_const = 4'h0;
    d0 = done_pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_inv", int'(inv_cnt), 1);
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_inv", int'(inv_cnt), 0);
    chk("midrst_fail", int'(fail_cnt), 0);
    chk("midrst_ff", int'(first_fail), 0);
    chk("midrst_sk", int'({sk_t, sk_s}), 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_pulses - d0, 0);

    // Full sweep with ideal stub
    run_sweep(8'h00, 8'hFF, 1'b1, 4'h0, bc, pc);
    chk("full_fail", int'(fail_cnt), 0);
    chk("full_inv", int'(inv_cnt), model_inv);
    chk("full_done_pulses", pc, 1);
    chk("full_idx_nowrap", int'({sk_t, sk_s}), 8'hFF);
    repeat (3) @(negedge clk);
    chk("full_idle_busy", int'(busy), 0);

    // Abort during APPLY of idx 0x10
    sweep_lo = 8'h00; sweep_hi = 8'hFF; stub_mode = 1'b1;
    d0 = done_pulses;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if ({sk_t, sk_s} == 8'h10) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach_0x10", int'(found), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_inv_partial", int'(inv_cnt), 16);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_pulses - d0, 0);
    chk("abort_still_idle", int'(busy), 0);

    // Restart after abort: counts cleared, idx from new sweep_lo
    sweep_lo = 8'h81; sweep_hi = 8'h81; stub_mode = 1'b0; stub_const = 4'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_cleared", int'(inv_cnt), 0);
    chk("restart_idx", int'({sk_t, sk_s}), 8'h81);
    chk("restart_busy", int'(busy), 1);
    d0 = done_pulses;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (done) found = 1'b1;
      else @(negedge clk);
    end
    chk("restart_done_seen", int'(found), 1);
    chk("restart_inv", int'(inv_cnt), 1);
    chk("restart_fail", int'(fail_cnt), 1);
    chk("restart_ff", int'(first_fail), 8'h81);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
